// File: rtl/train_pkg.sv
// Shared types and defaults for the track segment arbiter.
package train_pkg;

    localparam int unsigned SPEED_W          = 8;
    localparam int unsigned POS_W            = 10;
    localparam int unsigned DEF_GUARD_CYCLES = 16;
    localparam int unsigned DEF_MAX_OCC      = 1024;
    localparam int unsigned DEF_CNT_W        = 11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT_A = 3'd1,
        ST_GRANT_B = 3'd2,
        ST_GUARD   = 3'd3,
        ST_EMERG   = 3'd4
    } state_e;

    typedef enum logic {
        TRAIN_A = 1'b0,
        TRAIN_B = 1'b1
    } train_id_e;

endpackage

// File: rtl/seg_timer.sv
// Saturating up-counter with synchronous clear and terminal-count compare.
module seg_timer #(
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc,
    output logic             at_tc_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_tc_c = (cnt_q == tc);

endmodule

// File: rtl/track_segment_arbiter.sv
// Grants a single-line track segment to train A or B with guard interval,
// speed forwarding, and emergency stop on brake or occupancy timeout.
module track_segment_arbiter
    import train_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int unsigned MAX_OCC      = DEF_MAX_OCC,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_a,
    input  logic               req_b,
    input  logic               exit_a,
    input  logic               exit_b,
    input  logic               brake,
    input  logic [SPEED_W-1:0] speed_limit,
    input  logic               fault_clr,
    output logic               grant_a,
    output logic               grant_b,
    output logic [SPEED_W-1:0] cmd_speed_a,
    output logic [SPEED_W-1:0] cmd_speed_b,
    output logic               emergency,
    output logic               timeout_fault
);

    localparam logic [CNT_W-1:0] GUARD_TC = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] OCC_TC   = CNT_W'(MAX_OCC - 1);

    state_e             state_q,  state_d;
    train_id_e          last_q,   last_d;
    logic               fault_q,  fault_d;
    logic               grant_a_q, grant_a_d;
    logic               grant_b_q, grant_b_d;
    logic [SPEED_W-1:0] cmd_a_q,  cmd_a_d;
    logic [SPEED_W-1:0] cmd_b_q,  cmd_b_d;
    logic               emerg_q,  emerg_d;

    logic               tmr_clr;
    logic               tmr_en;
    logic [CNT_W-1:0]   tmr_tc;
    logic               tmr_hit;

    // One counter serves both the guard interval and the occupancy limit.
    seg_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .tc      (tmr_tc),
        .at_tc_c (tmr_hit)
    );

    // Next state and registered-output values; priority brake > timeout > exit > request.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        fault_d = fault_q;
        tmr_en  = (state_q == ST_GRANT_A) || (state_q == ST_GRANT_B) || (state_q == ST_GUARD);
        tmr_tc  = (state_q == ST_GUARD) ? GUARD_TC : OCC_TC;

        unique case (state_q)
            ST_IDLE: begin
                if (brake) begin
                    state_d = ST_EMERG;
                end else if (req_a && req_b) begin
                    state_d = (last_q == TRAIN_B) ? ST_GRANT_A : ST_GRANT_B;
                end else if (req_a) begin
                    state_d = ST_GRANT_A;
                end else if (req_b) begin
                    state_d = ST_GRANT_B;
                end
            end
            ST_GRANT_A: begin
                if (brake) begin
                    state_d = ST_EMERG;
                end else if (tmr_hit) begin
                    state_d = ST_EMERG;
                    fault_d = 1'b1;
                end else if (exit_a) begin
                    state_d = ST_GUARD;
                    last_d  = TRAIN_A;
                end
            end
            ST_GRANT_B: begin
                if (brake) begin
                    state_d = ST_EMERG;
                end else if (tmr_hit) begin
                    state_d = ST_EMERG;
                    fault_d = 1'b1;
                end else if (exit_b) begin
                    state_d = ST_GUARD;
                    last_d  = TRAIN_B;
                end
            end
            ST_GUARD: begin
                if (brake) begin
                    state_d = ST_EMERG;
                end else if (tmr_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMERG: begin
                if (!brake && fault_clr) begin
                    state_d = ST_GUARD;
                    fault_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every transition restarts the counter for the state being entered.
        tmr_clr = (state_d != state_q);

        grant_a_d = (state_d == ST_GRANT_A);
        grant_b_d = (state_d == ST_GRANT_B);
        emerg_d   = (state_d == ST_EMERG);
        // Speed is forwarded only while a grant is held across the edge, giving one cycle of lag.
        cmd_a_d   = ((state_q == ST_GRANT_A) && grant_a_d) ? speed_limit : '0;
        cmd_b_d   = ((state_q == ST_GRANT_B) && grant_b_d) ? speed_limit : '0;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= TRAIN_B;
            fault_q   <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            cmd_a_q   <= '0;
            cmd_b_q   <= '0;
            emerg_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            fault_q   <= fault_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            cmd_a_q   <= cmd_a_d;
            cmd_b_q   <= cmd_b_d;
            emerg_q   <= emerg_d;
        end
    end

    assign grant_a       = grant_a_q;
    assign grant_b       = grant_b_q;
    assign cmd_speed_a   = cmd_a_q;
    assign cmd_speed_b   = cmd_b_q;
    assign emergency     = emerg_q;
    assign timeout_fault = fault_q;

endmodule

// File: doc/track_segment_arbiter.md
Name: track_segment_arbiter

Overview:
Sequential arbiter that shares one single-line track segment between two trains (A and B).
- Grants the segment to one train at a time and enforces a guard interval between occupancies.
- Forwards the segment speed limit from the speed controller to the granted train only.
- Forces an emergency stop on a collision-detector brake or an occupancy timeout.
- Sits between train_info/collision_detector/train_speed_controller and the per-train speed command path.

Parameters:
GUARD_CYCLES, 16, idle cycles after a train exits before any new grant (min 1)
MAX_OCC, 1024, max cycles a train may hold the segment before timeout fault (min 2)
CNT_W, 11, width of the shared occupancy/guard counter; must hold max(GUARD_CYCLES, MAX_OCC)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req_a  input  1  train A requests the segment (level)
req_b  input  1  train B requests the segment (level)
exit_a  input  1  train A has left the segment (pulse or level)
exit_b  input  1  train B has left the segment (pulse or level)
brake  input  1  brake from collision_detector (level)
speed_limit  input  8  segment speed limit from train_speed_controller
fault_clr  input  1  operator acknowledge; releases emergency, clears fault
grant_a  output  1  train A owns the segment
grant_b  output  1  train B owns the segment
cmd_speed_a  output  8  speed command to train A
cmd_speed_b  output  8  speed command to train B
emergency  output  1  emergency stop active
timeout_fault  output  1  sticky occupancy-timeout flag

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - grant_a = grant_b = 0; cmd_speed_a = cmd_speed_b = 0.
  - emergency = 0; timeout_fault = 0; counter = 0.
  - last_served = B, so A wins the first tie.
- Reset asserted mid-operation returns to the reset values immediately, with no guard interval.
- States: IDLE, GRANT_A, GRANT_B, GUARD, EMERG.
- Priority in every state: brake > timeout > exit > request.
- IDLE:
  - brake = 1 -> EMERG.
  - req_a & req_b -> grant the train that is not last_served.
  - Single request -> grant that train.
  - Latency: the grant output is high one cycle after the request is sampled.
  - Counter cleared on entry to GRANT_x.
- GRANT_x:
  - grant_x = 1; cmd_speed_x = speed_limit, re-registered every cycle (1-cycle lag).
  - Other train's grant = 0 and cmd_speed = 0.
  - Counter increments, saturating.
  - exit_x = 1 -> GUARD; last_served = x; counter cleared.
  - Exit of the non-granted train is ignored.
  - Dropping req_x does not release the grant; only exit_x does.
  - Counter == MAX_OCC-1 with no exit -> timeout_fault = 1 and state -> EMERG.
  - brake = 1 -> EMERG, even if exit_x is high in the same cycle.
- GUARD:
  - No grants; both cmd_speed = 0.
  - Counter increments; at GUARD_CYCLES-1 -> IDLE.
  - Requests arriving during GUARD are honoured from IDLE, so the first grant comes GUARD_CYCLES+1 cycles after the exit sample.
  - brake = 1 -> EMERG.
- EMERG:
  - emergency = 1; both grants = 0; both cmd_speed = 0.
  - Outputs take effect the cycle after brake or timeout is sampled.
  - Leaves only when brake = 0 and fault_clr = 1 in the same cycle -> GUARD (counter cleared); timeout_fault clears on that same edge.
  - fault_clr while brake = 1 is ignored.
- Invariants (assertions):
  - grant_a & grant_b never both 1.
  - cmd_speed_x nonzero only when grant_x = 1.
  - emergency = 1 implies both grants = 0.
- fault_clr outside EMERG has no effect.
- speed_limit = 0 yields a grant with a zero command; this is legal.

Decomposition:
- Shared package (train_pkg): state enum, ID constants TRAIN_A/TRAIN_B, default GUARD_CYCLES/MAX_OCC, SPEED_W = 8, POS_W = 10.
- Optional sub-module seg_timer: saturating up-counter with clear and terminal-count compare, reused for guard and occupancy.
- FSM and output registers stay in track_segment_arbiter.

Test Plan:
1. Reset, then req_a = 1, speed_limit = 40 -> grant_a = 1 on the next cycle; cmd_speed_a = 40 one cycle later; grant_b = 0, cmd_speed_b = 0.
2. req_a and req_b rise on the same cycle from reset -> A granted. Pulse exit_a, hold req_b -> grant_b rises exactly 17 cycles after the exit_a sample (GUARD_CYCLES = 16). Next tie -> A again (alternation).
3. During GRANT_B (speed_limit = 60), assert brake together with exit_b -> next cycle emergency = 1, all grants and speeds 0. fault_clr while brake = 1 has no effect. brake = 0 plus fault_clr -> GUARD, then IDLE.
4. MAX_OCC = 8: grant A, never exit -> after 8 cycles timeout_fault = 1, emergency = 1. fault_clr with brake = 0 clears both and enters GUARD.
5. During GRANT_A, pulse exit_b and drop req_a -> grant_a stays 1; cmd_speed_a tracks speed_limit stepping 80 -> 20 with 1-cycle lag.
6. Assert rst_n = 0 mid-GUARD and mid-EMERG -> all outputs 0 asynchronously. After release, req_b is granted the cycle after it is sampled.
